// File: rtl/chn_pkg.sv
// Shared definitions for the TRN tx channel arbiter: FSM encoding, parameter
// defaults and the counter/pointer width helper.
package chn_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEL   = 3'd1,
        GRANT = 3'd2,
        BUSY  = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam int NCHN_DEF  = 4;
    localparam int DWELL_DEF = 4;
    localparam int TMO_DEF   = 1023;

    // ceil(log2(v)); callers pass TMO+1 to size a counter that can hold TMO
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/chn_arb_rr_pick.sv
// Round-robin search: first set request bit at or after ptr, wrapping modulo NCHN.
module rr_pick
    import chn_pkg::*;
#(
    parameter int NCHN = NCHN_DEF,
    parameter int PW   = clog2(NCHN)
)(
    input  logic [NCHN-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   index,
    output logic            valid
);

    int j;

    // Walk offsets from the far end so the nearest requester is written last
    always_comb begin
        index = '0;
        valid = 1'b0;
        j     = 0;
        for (int k = NCHN - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NCHN) j = j - NCHN;
            if (req[j]) begin
                index = PW'(j);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/chn_arb.sv
// Token arbiter sharing one PCIe endpoint TRN tx port among NCHN channels:
// round-robin grants, idle-dwell release, TMO forced release, sticky error flag.
module chn_arb
    import chn_pkg::*;
#(
    parameter int NCHN  = NCHN_DEF,
    parameter int DWELL = DWELL_DEF,
    parameter int TMO   = TMO_DEF
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NCHN-1:0] chn_reqep,
    input  logic [NCHN-1:0] chn_drvn,
    output logic [NCHN-1:0] chn_trn,
    output logic            arb_err,
    output logic            arb_tmo
);

    localparam int PW = clog2(NCHN);
    localparam int CW = clog2(TMO + 1);

    state_t          state, nxt;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   ptr, pick, rr_idx, sel_pick;
    logic            rr_vld, drv_pick, tmo_hit;

    rr_pick #(.NCHN(NCHN), .PW(PW)) u_pick (
        .req   (chn_reqep),
        .ptr   (ptr),
        .index (rr_idx),
        .valid (rr_vld)
    );

    assign sel_pick = rr_vld ? rr_idx : ptr;
    assign drv_pick = chn_drvn[pick];

    always_comb begin
        nxt     = state;
        tmo_hit = 1'b0;
        case (state)
            IDLE:  nxt = SEL;
            SEL:   nxt = GRANT;
            GRANT: begin
                if (drv_pick)                      nxt = BUSY;
                else if (cnt >= CW'(DWELL - 1))    nxt = GAP;
            end
            BUSY: begin
                if (!drv_pick) begin
                    nxt = GAP;
                end else if (cnt >= CW'(TMO - 1)) begin
                    nxt     = GAP;
                    tmo_hit = 1'b1;
                end
            end
            GAP:     nxt = SEL;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            ptr     <= '0;
            pick    <= '0;
            chn_trn <= '0;
            arb_err <= 1'b0;
            arb_tmo <= 1'b0;
        end else begin
            state   <= nxt;
            arb_tmo <= tmo_hit;
            // counter restarts on every state change and saturates at all-ones
            if (nxt != state)  cnt <= '0;
            else if (!(&cnt))  cnt <= cnt + CW'(1);
            if (state == SEL)  pick <= sel_pick;
            if (state == GAP)  ptr  <= (pick == PW'(NCHN - 1)) ? '0 : pick + PW'(1);
            if (state == SEL)
                chn_trn <= NCHN'(1) << sel_pick;
            else if (!(nxt == GRANT || nxt == BUSY))
                chn_trn <= '0;
            // chn_trn is zero in SEL/GAP, so any drvn there counts as an error
            if (state != IDLE && |(chn_drvn & ~chn_trn))
                arb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_chn_arb.sv
// Self-checking bench for chn_arb: directed scenarios plus randomized traffic
// checked against a grant-episode reference model.
module tb_chn_arb;

    localparam int N  = 4;
    localparam int DW = 4;
    localparam int TM = 1023;
    localparam int L  = 400;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] drv = '0;
    logic [N-1:0] trn;
    logic         err, tmo;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [N-1:0] tl [L];
    logic [N-1:0] rl [L];
    logic [N-1:0] dl [L];
    logic         ml [L];
    logic         el [L];
    logic [N-1:0] ex [L];
    logic         et [L];
    logic         ee [L];

    chn_arb #(.NCHN(N), .DWELL(DW), .TMO(TM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .chn_reqep (req),
        .chn_drvn  (drv),
        .chn_trn   (trn),
        .arb_err   (err),
        .arb_tmo   (tmo)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] bit_of(input int c);
        logic [N-1:0] v;
        v = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    // Cycle 0 is the IDLE cycle right after reset release; samples are taken at negedges
    task automatic start();
        rst_n = 1'b0;
        req   = '0;
        drv   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = '1;
        drv   = '1;
        #3;
        total++; if (trn !== '0)  begin bad++; $display("FAIL reset_trn got=%b want=0000", trn); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
        total++; if (tmo !== 1'b0) begin bad++; $display("FAIL reset_tmo got=%b want=0", tmo); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (trn !== '0)  begin bad++; $display("FAIL reset_hold_trn got=%b want=0000", trn); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_hold_err got=%b want=0", err); end
    endtask

    // No requests: each channel in turn gets DWELL cycles, then two empty cycles
    task automatic test_idle_rr();
        logic [N-1:0] e;
        start();
        for (int n = 0; n < 32; n++) begin
            if (n < 2) e = '0;
            else e = (((n - 2) % (DW + 2)) < DW) ? bit_of(((n - 2) / (DW + 2)) % N) : '0;
            total++;
            if (trn !== e) begin bad++; $display("FAIL idle_rr cyc=%0d got=%b want=%b", n, trn, e); end
            tick();
        end
    endtask

    // Request from ch2, ch2 drives 10 cycles; release lands one cycle after drvn falls
    task automatic test_req_drive();
        logic [N-1:0] e;
        start();
        req = 4'b0100;
        for (int n = 0; n < 19; n++) begin
            if (n >= 2 && n <= 12) e = 4'b0100;
            else if (n >= 15)      e = 4'b1000;
            else                   e = '0;
            total++;
            if (trn !== e) begin bad++; $display("FAIL req_drive cyc=%0d got=%b want=%b", n, trn, e); end
            if (n == 2) req = '0;
            drv = (n >= 2 && n <= 11) ? 4'b0100 : '0;
            tick();
        end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL req_drive_err got=%b want=0", err); end
    endtask

    // drvn for a single grant cycle: token kept one more (BUSY) cycle, then GAP
    task automatic test_one_cycle();
        logic [N-1:0] e;
        start();
        for (int n = 0; n < 8; n++) begin
            if (n == 2 || n == 3)      e = 4'b0001;
            else if (n >= 6)           e = 4'b0010;
            else                       e = '0;
            total++;
            if (trn !== e) begin bad++; $display("FAIL one_cycle cyc=%0d got=%b want=%b", n, trn, e); end
            drv = (n == 2) ? 4'b0001 : '0;
            tick();
        end
    endtask

    // ch2 idle grant leaves ptr=3; requests 1001 must give 1000 then 0001
    task automatic test_wrap();
        logic [N-1:0] e;
        start();
        req = 4'b0100;
        for (int n = 0; n < 18; n++) begin
            if (n >= 2 && n <= 5)        e = 4'b0100;
            else if (n >= 8 && n <= 11)  e = 4'b1000;
            else if (n >= 14)            e = 4'b0001;
            else                         e = '0;
            total++;
            if (trn !== e) begin bad++; $display("FAIL wrap cyc=%0d got=%b want=%b", n, trn, e); end
            if (n == 2) req = 4'b1001;
            tick();
        end
    endtask

    task automatic test_err();
        start();
        for (int n = 0; n < 12; n++) begin
            total++;
            if (err !== (n >= 4)) begin bad++; $display("FAIL err_sticky cyc=%0d got=%b want=%b", n, err, n >= 4); end
            drv = (n == 3) ? 4'b0010 : '0;
            tick();
        end
        rst_n = 1'b0;
        #1;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", err); end
    endtask

    task automatic test_rst_busy();
        logic [N-1:0] e;
        start();
        req = 4'b1000;
        for (int n = 0; n < 7; n++) begin
            if (n >= 2) begin
                total++;
                if (trn !== 4'b1000) begin bad++; $display("FAIL rst_busy_hold cyc=%0d got=%b want=1000", n, trn); end
            end
            if (n == 2) req = '0;
            drv = (n >= 2) ? 4'b1000 : '0;
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        total++; if (trn !== '0) begin bad++; $display("FAIL rst_busy_async got=%b want=0000", trn); end
        drv = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            e = (n >= 2) ? 4'b0001 : '0;
            total++;
            if (trn !== e) begin bad++; $display("FAIL rst_busy_after cyc=%0d got=%b want=%b", n, trn, e); end
            tick();
        end
    endtask

    task automatic test_tmo();
        int pulses, pcyc;
        pulses = 0;
        pcyc   = -1;
        start();
        req = 4'b0010;
        for (int n = 0; n < 2004; n++) begin
            if (tmo === 1'b1) begin pulses++; pcyc = n; end
            if (n == 1025) begin
                total++;
                if (trn !== 4'b0010) begin bad++; $display("FAIL tmo_hold got=%b want=0010", trn); end
            end
            if (n == 1026) begin
                total++;
                if (trn !== '0) begin bad++; $display("FAIL tmo_release got=%b want=0000", trn); end
                total++;
                if (err !== 1'b0) begin bad++; $display("FAIL tmo_err_early got=%b want=0", err); end
            end
            if (n == 1027) begin
                total++;
                if (err !== 1'b1) begin bad++; $display("FAIL tmo_err_gap got=%b want=1", err); end
            end
            if (n == 2) req = '0;
            drv = (n >= 2 && n <= 2001) ? 4'b0010 : '0;
            tick();
        end
        total++; if (pulses != 1)  begin bad++; $display("FAIL tmo_pulses got=%0d want=1", pulses); end
        total++; if (pcyc != 1026) begin bad++; $display("FAIL tmo_cycle got=%0d want=1026", pcyc); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL tmo_err_sticky got=%b want=1", err); end
    endtask

    // Random requests; each grantee randomly ignores the token or drives for a while
    task automatic test_random(input int seed_run);
        int gch, dstart, dlen, s, p, ch, lim, len, bs, g;
        bit nodrive, busy, hit, found;
        logic [N-1:0] prev;
        gch = -1; dstart = 0; dlen = 0; nodrive = 1'b1; prev = '0;
        start();
        for (int n = 0; n < L; n++) begin
            tl[n] = trn; ml[n] = tmo; el[n] = err;
            if (trn != '0 && trn != prev) begin
                for (int c = 0; c < N; c++) if (trn[c]) gch = c;
                nodrive = ($urandom_range(0, 2) == 0);
                dstart  = n + int'($urandom_range(0, DW - 1));
                dlen    = int'($urandom_range(1, 12));
            end
            prev = trn;
            if ($urandom_range(0, 2) == 0) req = N'($urandom);
            drv = '0;
            if (!nodrive && gch >= 0 && n >= dstart && n < dstart + dlen) drv = bit_of(gch);
            rl[n] = req; dl[n] = drv;
            tick();
        end
        for (int n = 0; n < L; n++) begin ex[n] = '0; et[n] = 1'b0; ee[n] = 1'b0; end
        // Episode model: SEL picks, grant lasts DWELL idle cycles or until drive ends/TMO, then GAP+SEL
        s = 1; p = 0; lim = L;
        while (s < L) begin
            ch = p; found = 1'b0;
            for (int k = 0; k < N; k++)
                if (!found && rl[s][(p + k) % N]) begin ch = (p + k) % N; found = 1'b1; end
            len = 0; busy = 1'b0; bs = 0; hit = 1'b0;
            for (int i = 0; s + 1 + i < L; i++) begin
                g = s + 1 + i;
                ex[g] = bit_of(ch);
                if (!busy) begin
                    if (dl[g][ch]) begin busy = 1'b1; bs = i; end
                    else if (i == DW - 1) begin len = i + 1; break; end
                end else if (!dl[g][ch]) begin len = i + 1; break; end
                else if (i - bs == TM) begin len = i + 1; hit = 1'b1; break; end
            end
            if (len == 0) begin lim = s + 1; break; end
            if (hit && s + len + 1 < L) et[s + len + 1] = 1'b1;
            p = (ch + 1) % N;
            s = s + len + 2;
        end
        for (int n = 1; n < L; n++)
            ee[n] = ee[n - 1] | ((n - 1 >= 1) && ((dl[n - 1] & ~ex[n - 1]) != '0));
        for (int n = 0; n < lim; n++) begin
            total++;
            if (tl[n] !== ex[n]) begin
                bad++;
                if (bad < 20) $display("FAIL rand%0d_trn cyc=%0d got=%b want=%b", seed_run, n, tl[n], ex[n]);
            end
            total++;
            if (ml[n] !== et[n]) begin
                bad++;
                if (bad < 20) $display("FAIL rand%0d_tmo cyc=%0d got=%b want=%b", seed_run, n, ml[n], et[n]);
            end
            total++;
            if (el[n] !== ee[n]) begin
                bad++;
                if (bad < 20) $display("FAIL rand%0d_err cyc=%0d got=%b want=%b", seed_run, n, el[n], ee[n]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_rr();
        test_req_drive();
        test_one_cycle();
        test_wrap();
        test_err();
        test_rst_busy();
        test_tmo();
        for (int r = 0; r < 3; r++) test_random(r);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chn_arb.md
CHN_ARB -- requirements
Module: chn_arb

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter NCHN, default 4, number of channels sharing the PCIe endpoint TRN tx port (legal range 2..8).
REQ-003 Parameter DWELL, default 4, cycles a token waits for an idle channel to start driving.
REQ-004 Parameter TMO, default 1023, maximum cycles a channel may hold the token while driving.
REQ-005 clk  input  1  pcie_clk domain clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 chn_reqep  input  NCHN  per-channel request for the endpoint, level.
REQ-008 chn_drvn  input  NCHN  per-channel "driving TRN tx" indication, level.
REQ-009 chn_trn  output  NCHN  one-hot token grant (my turn) per channel.
REQ-010 arb_err  output  1  sticky protocol-error flag.
REQ-011 arb_tmo  output  1  one-cycle pulse when a TMO expiry forces release.

Function
REQ-012 chn_trn SHALL be zero or one-hot in every cycle; chn_trn SHALL be registered.
REQ-013 FSM states SHALL be IDLE, SEL, GRANT, BUSY, GAP.
REQ-014 IDLE: chn_trn=0; next cycle goes to SEL.
REQ-015 SEL (1 cycle): if any chn_reqep bit is set, pick the first requester at or after ptr (wrap modulo NCHN); otherwise pick ptr; go to GRANT with chn_trn set for the pick.
REQ-016 GRANT: if chn_drvn[pick]=1 go to BUSY; else after DWELL cycles in GRANT with chn_drvn[pick]=0, go to GAP.
REQ-017 BUSY: hold chn_trn; when chn_drvn[pick] falls go to GAP; if the BUSY count reaches TMO, pulse arb_tmo and go to GAP.
REQ-018 GAP (1 cycle): chn_trn=0; ptr <= pick+1 modulo NCHN (NCHN-1 wraps to 0); go to SEL.
REQ-019 The cycle counter SHALL be ceil(log2(TMO+1)) bits, cleared on every state entry, saturating (no wrap).
REQ-020 Token-to-token latency for back-to-back idle channels SHALL be DWELL+2 cycles (GRANT dwell, GAP, SEL).
REQ-021 A chn_reqep bit rising during BUSY SHALL be ignored until the next SEL; the active holder is never pre-empted except by TMO.
REQ-022 A chn_drvn bit set for any channel other than the current grant, or any chn_drvn set in GAP or SEL, SHALL set arb_err until reset.
REQ-023 chn_drvn[pick] asserting and deasserting in the same GRANT cycle window of one cycle SHALL be treated as BUSY for one cycle, then GAP.
REQ-024 If chn_drvn[pick] stays high after TMO release, arb_err SHALL set in the GAP cycle.

Reset
REQ-025 On rst_n low, asynchronously: state=IDLE, ptr=0, counter=0, chn_trn=0, arb_err=0, arb_tmo=0.
REQ-026 Reset asserted mid-BUSY SHALL drop chn_trn immediately; after release the first grant SHALL go to channel 0 (or first requester from 0).

Structure
REQ-027 FSM state encoding, NCHN/DWELL/TMO defaults and the ceil-log2 width function SHALL live in the shared package chn_pkg.
REQ-028 The round-robin first-requester-from-ptr search SHALL be one combinational sub-module rr_pick (inputs req, ptr; output index, valid).
REQ-029 Implementation SHALL be a single clock domain with no latches.

Verification
REQ-030 No requests, no drvn, NCHN=4, DWELL=4 -> chn_trn cycles 0001,0010,0100,1000,0001 with each grant 4 cycles wide and 2 zero-grant cycles between grants.
REQ-031 ptr=0, chn_reqep=0100 -> next grant 0100; channel 2 drives 10 cycles -> chn_trn held 10 cycles, then GAP, then grant 1000.
REQ-032 Channel 1 granted, holds chn_drvn high for 2000 cycles with TMO=1023 -> arb_tmo pulses once at 1023 BUSY cycles, token released, arb_err=1.
REQ-033 Channel 0 granted, chn_drvn=0010 asserted -> arb_err=1 next cycle and stays 1 until rst_n low.
REQ-034 rst_n low during BUSY on channel 3 -> chn_trn=0 without a clock edge; after release first grant is 0001.
REQ-035 chn_reqep=1001 with ptr=3 -> grant 1000 then 0001 (wrap-around), never 0010 or 0100 in between.
